// File: rtl/alu_issue_queue.sv
// alu_issue_queue
//   Reservation station and issue scheduler for the combinational ALU.
//   Dispatched micro-ops wait here until both source operands are present.
//   Operand values are captured from two result broadcast buses: bus 0 is
//   the ALU loopback and bus 1 is the load/store unit. Each cycle at most one
//   ready entry is issued, chosen round-robin, onto registered ex* outputs.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   clear               synchronous flush of every entry (branch/jump redirect)
//   disp_*              dispatch request: opcode, operand values/tags, dest, pc
//   full                no free entry; a dispatch request is ignored
//   cdb0_*, cdb1_*      result broadcast buses (enable, tag, data)
//   ex_alu_en           one-cycle issue pulse to the ALU
//   exsrc1/2, expc,
//   exaluop, exdest     issued micro-op fields, held while ex_alu_en is low
module alu_issue_queue #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int OP_W     = 5,
  parameter int TAG_W    = 4,
  parameter int TAG_FREE = 0,
  parameter int ENTRIES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              disp_en,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [DATA_W-1:0] disp_src1,
  input  logic [DATA_W-1:0] disp_src2,
  input  logic [TAG_W-1:0]  disp_tag1,
  input  logic [TAG_W-1:0]  disp_tag2,
  input  logic [TAG_W-1:0]  disp_dest,
  input  logic [ADDR_W-1:0] disp_pc,
  output logic              full,
  input  logic              cdb0_en,
  input  logic [TAG_W-1:0]  cdb0_tag,
  input  logic [DATA_W-1:0] cdb0_data,
  input  logic              cdb1_en,
  input  logic [TAG_W-1:0]  cdb1_tag,
  input  logic [DATA_W-1:0] cdb1_data,
  output logic              ex_alu_en,
  output logic [DATA_W-1:0] exsrc1,
  output logic [DATA_W-1:0] exsrc2,
  output logic [ADDR_W-1:0] expc,
  output logic [OP_W-1:0]   exaluop,
  output logic [TAG_W-1:0]  exdest
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CNT_W = $clog2(ENTRIES + 1);
  localparam logic [TAG_W-1:0] FREE     = TAG_W'(TAG_FREE);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ENTRIES);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } opnd_t;

  // Operand capture: a waiting operand takes the value of a matching
  // broadcast; bus 0 wins when both buses carry the same tag.
  function automatic opnd_t snoop(
    input opnd_t             o,
    input logic              c0_en,
    input logic [TAG_W-1:0]  c0_tag,
    input logic [DATA_W-1:0] c0_data,
    input logic              c1_en,
    input logic [TAG_W-1:0]  c1_tag,
    input logic [DATA_W-1:0] c1_data
  );
    opnd_t r;
    r = o;
    if (o.tag != FREE) begin
      if (c0_en && (c0_tag == o.tag)) begin
        r.tag = FREE;
        r.val = c0_data;
      end else if (c1_en && (c1_tag == o.tag)) begin
        r.tag = FREE;
        r.val = c1_data;
      end
    end
    return r;
  endfunction

  logic [ENTRIES-1:0] busy;
  logic [OP_W-1:0]    e_op   [ENTRIES];
  logic [ADDR_W-1:0]  e_pc   [ENTRIES];
  logic [TAG_W-1:0]   e_dest [ENTRIES];
  opnd_t              e_src1 [ENTRIES];
  opnd_t              e_src2 [ENTRIES];
  logic [IDX_W-1:0]   rr_ptr;

  logic [ENTRIES-1:0] ready;
  logic [CNT_W-1:0]   busy_cnt;
  logic               sel_vld;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   scan_idx;
  logic [IDX_W-1:0]   free_idx;
  logic               accept;
  opnd_t              disp_opnd1;
  opnd_t              disp_opnd2;

  // Select stage: readiness, occupancy, free slot and round-robin choice are
  // all taken from registered entry state only.
  always_comb begin
    busy_cnt = '0;
    ready    = '0;
    free_idx = '0;
    sel_vld  = 1'b0;
    sel_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      busy_cnt = busy_cnt + CNT_W'(busy[i]);
      ready[i] = busy[i] && (e_src1[i].tag == FREE) && (e_src2[i].tag == FREE);
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
    end
    // ENTRIES is a power of two, so the index addition wraps naturally.
    for (int k = 0; k < ENTRIES; k++) begin
      scan_idx = rr_ptr + IDX_W'(k);
      if (!sel_vld && ready[scan_idx]) begin
        sel_vld = 1'b1;
        sel_idx = scan_idx;
      end
    end
  end

  assign full   = (busy_cnt == CNT_FULL);
  assign accept = disp_en && !full && !clear;

  assign disp_opnd1 = snoop({disp_tag1, disp_src1}, cdb0_en, cdb0_tag, cdb0_data,
                            cdb1_en, cdb1_tag, cdb1_data);
  assign disp_opnd2 = snoop({disp_tag2, disp_src2}, cdb0_en, cdb0_tag, cdb0_data,
                            cdb1_en, cdb1_tag, cdb1_data);

  // Issue stage: control state and the registered ALU-facing outputs.
  // A slot freed here and a slot filled by dispatch are never the same entry,
  // because dispatch only targets entries that were not busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= '0;
      rr_ptr    <= '0;
      ex_alu_en <= 1'b0;
      exsrc1    <= '0;
      exsrc2    <= '0;
      expc      <= '0;
      exaluop   <= '0;
      exdest    <= FREE;
    end else if (clear) begin
      busy      <= '0;
      ex_alu_en <= 1'b0;
    end else begin
      ex_alu_en <= sel_vld;
      if (sel_vld) begin
        busy[sel_idx] <= 1'b0;
        rr_ptr        <= sel_idx + IDX_W'(1);
        exsrc1        <= e_src1[sel_idx].val;
        exsrc2        <= e_src2[sel_idx].val;
        expc          <= e_pc[sel_idx];
        exaluop       <= e_op[sel_idx];
        exdest        <= e_dest[sel_idx];
      end
      if (accept) busy[free_idx] <= 1'b1;
    end
  end

  // Entry payload: written on dispatch, otherwise snooping the buses every
  // cycle. Contents of non-busy entries are don't-care, so no reset here.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (accept && (free_idx == IDX_W'(i))) begin
        e_op[i]   <= disp_op;
        e_pc[i]   <= disp_pc;
        e_dest[i] <= disp_dest;
        e_src1[i] <= disp_opnd1;
        e_src2[i] <= disp_opnd2;
      end else begin
        e_src1[i] <= snoop(e_src1[i], cdb0_en, cdb0_tag, cdb0_data,
                           cdb1_en, cdb1_tag, cdb1_data);
        e_src2[i] <= snoop(e_src2[i], cdb0_en, cdb0_tag, cdb0_data,
                           cdb1_en, cdb1_tag, cdb1_data);
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int OW = 5;
  localparam int TW = 4;
  localparam int E  = 4;

  logic          clk, rst, clear, disp_en, full;
  logic [OW-1:0] disp_op, exaluop;
  logic [DW-1:0] disp_src1, disp_src2, cdb0_data, cdb1_data, exsrc1, exsrc2;
  logic [TW-1:0] disp_tag1, disp_tag2, disp_dest, cdb0_tag, cdb1_tag, exdest;
  logic [AW-1:0] disp_pc, expc;
  logic          cdb0_en, cdb1_en, ex_alu_en;

  alu_issue_queue #(.DATA_W(DW), .ADDR_W(AW), .OP_W(OW), .TAG_W(TW),
                    .TAG_FREE(0), .ENTRIES(E)) dut (
    .clk(clk), .rst(rst), .clear(clear), .disp_en(disp_en), .disp_op(disp_op),
    .disp_src1(disp_src1), .disp_src2(disp_src2), .disp_tag1(disp_tag1),
    .disp_tag2(disp_tag2), .disp_dest(disp_dest), .disp_pc(disp_pc), .full(full),
    .cdb0_en(cdb0_en), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
    .cdb1_en(cdb1_en), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
    .ex_alu_en(ex_alu_en), .exsrc1(exsrc1), .exsrc2(exsrc2), .expc(expc),
    .exaluop(exaluop), .exdest(exdest));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    clear = 0; disp_en = 0; disp_op = '0; disp_src1 = '0; disp_src2 = '0;
    disp_tag1 = '0; disp_tag2 = '0; disp_dest = '0; disp_pc = '0;
    cdb0_en = 0; cdb0_tag = '0; cdb0_data = '0;
    cdb1_en = 0; cdb1_tag = '0; cdb1_data = '0;
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    bit busy; bit [4:0] op; bit [31:0] pc; bit [3:0] dest;
    bit [3:0] t1; bit [31:0] v1; bit [3:0] t2; bit [31:0] v2;
  } ment_t;
  ment_t m[E];
  int m_ptr;
  bit m_en, m_full;
  bit [31:0] m_s1, m_s2, m_pc;
  bit [4:0] m_op;
  bit [3:0] m_dest;

  function automatic bit [35:0] wake(input bit [35:0] tv);
    if (tv[35:32] != 4'd0) begin
      if (cdb0_en && cdb0_tag == tv[35:32]) return {4'd0, cdb0_data};
      if (cdb1_en && cdb1_tag == tv[35:32]) return {4'd0, cdb1_data};
    end
    return tv;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < E; i++) m[i].busy = 0;
    m_ptr = 0; m_en = 0; m_full = 0;
    m_s1 = 0; m_s2 = 0; m_pc = 0; m_op = 0; m_dest = 0;
  endtask

  task automatic model_step();
    int cnt, fr, sel, idx;
    bit full_pre;
    cnt = 0;
    for (int i = 0; i < E; i++) if (m[i].busy) cnt++;
    full_pre = (cnt == E);
    fr = -1;
    for (int i = E - 1; i >= 0; i--) if (!m[i].busy) fr = i;
    sel = -1;
    for (int k = 0; k < E; k++) begin
      idx = (m_ptr + k) % E;
      if (sel < 0 && m[idx].busy && m[idx].t1 == 0 && m[idx].t2 == 0) sel = idx;
    end
    if (clear) begin
      for (int i = 0; i < E; i++) m[i].busy = 0;
      m_en = 0;
    end else begin
      m_en = (sel >= 0);
      if (sel >= 0) begin
        m_s1 = m[sel].v1; m_s2 = m[sel].v2; m_pc = m[sel].pc;
        m_op = m[sel].op; m_dest = m[sel].dest;
        m[sel].busy = 0;
        m_ptr = (sel + 1) % E;
      end
      for (int i = 0; i < E; i++) begin
        if (m[i].busy) begin
          {m[i].t1, m[i].v1} = wake({m[i].t1, m[i].v1});
          {m[i].t2, m[i].v2} = wake({m[i].t2, m[i].v2});
        end
      end
      if (disp_en && !full_pre) begin
        m[fr].busy = 1; m[fr].op = disp_op; m[fr].pc = disp_pc; m[fr].dest = disp_dest;
        {m[fr].t1, m[fr].v1} = wake({disp_tag1, disp_src1});
        {m[fr].t2, m[fr].v2} = wake({disp_tag2, disp_src2});
      end
    end
    cnt = 0;
    for (int i = 0; i < E; i++) if (m[i].busy) cnt++;
    m_full = (cnt == E);
  endtask

  function automatic bit [3:0] rtag();
    int v;
    v = $urandom_range(0, 8);
    return (v > 5) ? 4'd0 : 4'(v);
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst; bit clr; bit den;
    bit [3:0] t1; bit [3:0] t2; bit [3:0] dest;
    bit [31:0] s1; bit [31:0] s2;
    bit c0en; bit [3:0] c0tag; bit [31:0] c0data;
    bit c1en; bit [3:0] c1tag; bit [31:0] c1data;
    bit een; bit [31:0] es1; bit [31:0] es2; bit [3:0] edest; bit efull;
  } vec_t;
  localparam int NV = 38;
  vec_t tbl[NV];

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst,clr,den, t1,t2,dest, s1,s2, c0en,c0tag,c0data, c1en,c1tag,c1data, een,es1,es2,edest,efull
    tbl[0]  = '{0,0,1, 0,0,3,  5,7,  0,0,0,      0,0,0,       0,0,0,0,0};
    tbl[1]  = '{0,0,0, 0,0,0,  0,0,  0,0,0,      0,0,0,       1,5,7,3,0};
    tbl[2]  = '{0,0,1, 6,0,4,  0,2,  0,0,0,      0,0,0,       0,0,0,0,0};
    tbl[3]  = '{0,0,0, 0,0,0,  0,0,  0,0,0,      0,0,0,       0,0,0,0,0};
    tbl[4]  = '{0,0,0, 0,0,0,  0,0,  0,0,0,      1,6,'h1234,  0,0,0,0,0};
    tbl[5]  = '{0,0,0, 0,0,0,  0,0,  0,0,0,      0,0,0,       1,'h1234,2,4,0};
    tbl[6]  = '{0,0,1, 0,9,5,  1,0,  1,9,'hFF,   0,0,0,       0,0,0,0,0};
    tbl[7]  = '{0,0,0, 0,0,0,  0,0,  0,0,0,      0,0,0,       1,1,'hFF,5,0};
    tbl[8]  = '{0,0,1, 10,0,6, 0,6,  0,0,0,      0,0,0,       0,0,0,0,0};
    tbl[9]  = '{0,0,1, 11,0,7, 0,7,  0,0,0,      0,0,0,       0,0,0,0,0};
    tbl[10] = '{0,0,1, 12,0,8, 0,8,  0,0,0,      0,0,0,       0,0,0,0,0};
    tbl[11] = '{0,0,1, 13,0,9, 0,9,  0,0,0,      0,0,0,       0,0,0,0,1};
    tbl[12] = '{0,0,1, 0,0,15, 1,1,  0,0,0,      0,0,0,       0,0,0,0,1};
    tbl[13] = '{0,0,0, 0,0,0,  0,0,  1,11,'hAB,  0,0,0,       0,0,0,0,1};
    tbl[14] = '{0,0,0, 0,0,0,  0,0,  0,0,0,      0,0,0,       1,'hAB,7,7,0};
    tbl[15] = '{0,0,0, 0,0,0,  0,0,  1,10,'h10A, 1,12,'h10C,  0,0,0,0,0};
    tbl[16] = '{0,0,0, 0,0,0,  0,0,  1,13,'h10D, 0,0,0,       1,'h10C,8,8,0};
    tbl[17] = '{0,0,0, 0,0,0,  0,0,  0,0,0,      0,0,0,       1,'h10D,9,9,0};
    tbl[18] = '{0,0,0, 0,0,0,  0,0,  0,0,0,      0,0,0,       1,'h10A,6,6,0};
    tbl[19] = '{1,0,0, 0,0,0,  0,0,  0,0,0,      0,0,0,       0,0,0,0,0};
    tbl[20] = '{0,0,1, 14,0,1, 0,1,  0,0,0,      0,0,0,       0,0,0,0,0};
    tbl[21] = '{0,0,1, 14,0,2, 0,2,  0,0,0,      0,0,0,       0,0,0,0,0};
    tbl[22] = '{0,0,1, 14,0,3, 0,3,  0,0,0,      0,0,0,       0,0,0,0,0};
    tbl[23] = '{0,0,1, 14,0,4, 0,4,  0,0,0,      0,0,0,       0,0,0,0,1};
    tbl[24] = '{0,0,0, 0,0,0,  0,0,  1,14,'h77,  0,0,0,       0,0,0,0,1};
    tbl[25] = '{0,0,0, 0,0,0,  0,0,  0,0,0,      0,0,0,       1,'h77,1,1,0};
    tbl[26] = '{0,0,1, 15,0,10, 0,10, 0,0,0,     0,0,0,       1,'h77,2,2,0};
    tbl[27] = '{0,0,1, 13,0,12, 0,12, 0,0,0,     0,0,0,       1,'h77,3,3,0};
    tbl[28] = '{0,0,1, 15,0,11, 0,11, 0,0,0,     0,0,0,       1,'h77,4,4,0};
    tbl[29] = '{0,0,0, 0,0,0,  0,0,  0,0,0,      1,15,'h55,   0,0,0,0,0};
    tbl[30] = '{0,0,0, 0,0,0,  0,0,  0,0,0,      0,0,0,       1,'h55,10,10,0};
    tbl[31] = '{0,0,0, 0,0,0,  0,0,  0,0,0,      0,0,0,       1,'h55,11,11,0};
    tbl[32] = '{0,0,1, 12,0,13, 0,13, 0,0,0,     0,0,0,       0,0,0,0,0};
    tbl[33] = '{0,0,1, 12,0,14, 0,14, 0,0,0,     0,0,0,       0,0,0,0,0};
    tbl[34] = '{0,1,1, 0,0,15, 1,1,  1,12,'h99,  0,0,0,       0,0,0,0,0};
    tbl[35] = '{0,0,0, 0,0,0,  0,0,  0,0,0,      0,0,0,       0,0,0,0,0};
    tbl[36] = '{0,0,0, 0,0,0,  0,0,  1,13,'h33,  0,0,0,       0,0,0,0,0};
    tbl[37] = '{0,0,0, 0,0,0,  0,0,  0,0,0,      0,0,0,       0,0,0,0,0};

    drive_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset en", ex_alu_en, 0);
    chk("reset full", full, 0);
    chk("reset exdest", exdest, 0);
    chk("reset exsrc1", exsrc1, 0);
    chk("reset exsrc2", exsrc2, 0);
    chk("reset expc", expc, 0);
    chk("reset exaluop", exaluop, 0);
    rst = 0;

    for (int r = 0; r < NV; r++) begin
      rst = tbl[r].rst; clear = tbl[r].clr; disp_en = tbl[r].den;
      disp_tag1 = tbl[r].t1; disp_tag2 = tbl[r].t2; disp_dest = tbl[r].dest;
      disp_src1 = tbl[r].s1; disp_src2 = tbl[r].s2;
      disp_op = 5'(tbl[r].dest) + 5'd1; disp_pc = 32'(tbl[r].dest) << 2;
      cdb0_en = tbl[r].c0en; cdb0_tag = tbl[r].c0tag; cdb0_data = tbl[r].c0data;
      cdb1_en = tbl[r].c1en; cdb1_tag = tbl[r].c1tag; cdb1_data = tbl[r].c1data;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d ex_alu_en", r), ex_alu_en, tbl[r].een);
      chk($sformatf("vec%0d full", r), full, tbl[r].efull);
      if (tbl[r].een || tbl[r].rst) begin
        chk($sformatf("vec%0d exsrc1", r), exsrc1, tbl[r].es1);
        chk($sformatf("vec%0d exsrc2", r), exsrc2, tbl[r].es2);
        chk($sformatf("vec%0d exdest", r), exdest, tbl[r].edest);
        chk($sformatf("vec%0d exaluop", r), exaluop,
            tbl[r].rst ? 5'd0 : 5'(tbl[r].edest) + 5'd1);
        chk($sformatf("vec%0d expc", r), expc,
            tbl[r].rst ? 32'd0 : 32'(tbl[r].edest) << 2);
      end
    end
    rst = 0;
    drive_idle();

    // Reset asserted between edges takes effect immediately and drops entries.
    disp_en = 1; disp_dest = 6; disp_src1 = 'h11; disp_src2 = 'h22;
    disp_op = 5'd3; disp_pc = 'h40;
    @(posedge clk);
    #1;
    disp_dest = 7; disp_src1 = 'h33; disp_src2 = 'h44;
    @(posedge clk);
    #1;
    disp_en = 0;
    chk("midrst pre en", ex_alu_en, 1);
    chk("midrst pre exdest", exdest, 6);
    #2;
    rst = 1;
    #1;
    chk("midrst en", ex_alu_en, 0);
    chk("midrst exdest", exdest, 0);
    chk("midrst exsrc1", exsrc1, 0);
    chk("midrst expc", expc, 0);
    chk("midrst full", full, 0);
    @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    chk("midrst dropped", ex_alu_en, 0);

    // Randomized phase against the reference model.
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      clear = ($urandom_range(0, 31) == 0);
      disp_en = 1'($urandom_range(0, 1));
      disp_tag1 = rtag(); disp_tag2 = rtag();
      disp_src1 = $urandom; disp_src2 = $urandom;
      disp_dest = 4'($urandom_range(0, 15)); disp_op = 5'($urandom_range(0, 31));
      disp_pc = $urandom;
      cdb0_en = 1'($urandom_range(0, 1)); cdb0_tag = 4'($urandom_range(1, 5));
      cdb0_data = $urandom;
      cdb1_en = 1'($urandom_range(0, 1)); cdb1_tag = 4'($urandom_range(1, 5));
      cdb1_data = $urandom;
      if (cdb0_en && cdb1_en && cdb0_tag == cdb1_tag) cdb1_en = 0;
      if (rst) model_reset();
      else model_step();
      @(posedge clk);
      #1;
      chk("rnd ex_alu_en", ex_alu_en, m_en);
      chk("rnd full", full, m_full);
      chk("rnd exsrc1", exsrc1, m_s1);
      chk("rnd exsrc2", exsrc2, m_s2);
      chk("rnd expc", expc, m_pc);
      chk("rnd exaluop", exaluop, m_op);
      chk("rnd exdest", exdest, m_dest);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Reservation station and issue scheduler for the ALU execution unit. Holds dispatched ALU/jump micro-ops until both source operands are available. Captures operand values from two result broadcast buses (ALU loopback and load/store), and issues at most one ready entry per cycle to the combinational ALU through registered outputs. It sits between the dispatch stage and the ALU, and is flushed on a branch or jump redirect.

## Interface
Parameters:
- `DATA_W`, 32, operand/result width
- `ADDR_W`, 32, PC width
- `OP_W`, 5, decoded ALU opcode width
- `TAG_W`, 4, ROB tag width
- `TAG_FREE`, 0, tag value meaning "operand already valid / no destination"
- `ENTRIES`, 4, station depth (power of two, 2..8)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `clear`  in  1  synchronous flush; drops all entries
- `disp_en`  in  1  dispatch request
- `disp_op`  in  OP_W  opcode
- `disp_src1`, `disp_src2`  in  DATA_W  operand values, meaningful when the matching tag equals `TAG_FREE`
- `disp_tag1`, `disp_tag2`  in  TAG_W  producer tags; `TAG_FREE` means the value is present
- `disp_dest`  in  TAG_W  destination ROB tag
- `disp_pc`  in  ADDR_W  instruction PC
- `full`  out  1  no free entry; dispatch is refused
- `cdb0_en`, `cdb1_en`  in  1  broadcast valid for bus 0 (ALU) and bus 1 (LSU)
- `cdb0_tag`, `cdb1_tag`  in  TAG_W  broadcast tags
- `cdb0_data`, `cdb1_data`  in  DATA_W  broadcast values
- `ex_alu_en`  out  1  issue valid to the ALU
- `exsrc1`, `exsrc2`  out  DATA_W  issued operands
- `expc`  out  ADDR_W  issued PC
- `exaluop`  out  OP_W  issued opcode
- `exdest`  out  TAG_W  issued destination tag

## Operation
- Each entry holds: busy, op, pc, dest, and for each operand a value plus a tag. An operand is ready when its tag equals `TAG_FREE`. An entry is ready when it is busy and both operands are ready.
- `full` = (busy count == `ENTRIES`), taken from registered state.

Dispatch:
- A dispatch is accepted when `disp_en` is high, `full` is low and `clear` is low.
- It is written to the lowest-index non-busy entry.
- When `disp_en` is high while `full` is high, the request is ignored; the dispatcher must hold it.

Same-cycle bypass at dispatch:
- If `disp_tagN` != `TAG_FREE` and matches an active cdb tag in the same cycle, store that cdb data and set the tag to `TAG_FREE`.
- cdb0 has priority if both buses match; duplicate tags are illegal.

Wakeup:
- Every busy entry whose operand tag matches an active cdb captures that data and sets the tag to `TAG_FREE` at the edge.

Select:
- Round-robin among ready entries, starting at the index after the last issued entry (pointer reset to 0, so entry 0 has first priority).
- Readiness is evaluated on registered entry state only, so an operand woken in cycle t makes its entry eligible in cycle t+1.

Issue:
- The selected entry's fields are registered onto the `ex*` outputs, `ex_alu_en` is set to 1, and the entry's busy bit is cleared at the same edge.
- If no entry is ready, `ex_alu_en` is 0 and the other `ex*` outputs hold their previous values.

Simultaneous events:
- Issue and dispatch in the same cycle are both performed: count = count + accept − issue.
- A slot freed by issue becomes visible to `full` in the next cycle.

Clear:
- At the edge, all busy bits are cleared, `ex_alu_en` goes to 0 and the RR pointer is unchanged.
- `clear` overrides a simultaneous dispatch, wakeup and issue.

Reset:
- All busy bits are 0, the RR pointer is 0, `full` is 0 and `ex_alu_en` is 0.
- `exdest` resets to `TAG_FREE`; `exsrc1`, `exsrc2`, `expc` and `exaluop` reset to 0.
- Reset asserted mid-operation discards all entries immediately.

## Timing
- Dispatch with both operands ready at edge N: the entry is eligible in cycle N..N+1, and `ex_alu_en` is high after edge N+1 (one-cycle minimum latency).
- An operand broadcast in the dispatch cycle itself also gives a one-cycle minimum latency.
- An operand woken at edge M makes the entry issue no earlier than edge M+1.
- Throughput is one issue per cycle. `ex_alu_en` is a one-cycle pulse per issued op and has no stall input, because the ALU is combinational.
- `full` changes only at clock edges.

## Test plan
- Reset, then dispatch ADD (tags `TAG_FREE`, src1=5, src2=7, dest=3) → `ex_alu_en`=1 exactly one cycle later with `exsrc1`=5, `exsrc2`=7, `exdest`=3; `full`=0 throughout.
- Dispatch op with `disp_tag1`=6, then cdb1 broadcasts tag 6 data 0x1234 two cycles later → no issue before the broadcast; issue one cycle after it with `exsrc1`=0x1234.
- Dispatch with `disp_tag2`=9 in the same cycle as cdb0 tag 9 data 0xFF → entry issues next cycle with `exsrc2`=0xFF (bypass).
- Fill all 4 entries with tag-waiting ops → `full`=1 and a 5th dispatch is ignored. Broadcast one tag → that entry issues, and `full`=0 the cycle after the issue.
- 4 entries all ready → issued in order 0,1,2,3 on consecutive cycles. Then refill entries 0 and 2 with 2 ready, after the last issue at 3 → 0 issues before 2.
- 3 waiting entries, assert `clear` together with `disp_en` and a matching cdb → all entries dropped, the dispatch not accepted, `ex_alu_en`=0 and `full`=0 the next cycle. Assert `rst` mid-stream → outputs at reset values immediately.
